jtag_bsr_chain: RTL
===================

// Module: jtag_bsr_chain
// PURPOSE
//  Parametrised JTAG boundary-scan register wrapping an arbitrary CUT: N_IN input cells, N_OUT output cells,
//  plus a 1-bit bypass cell, all serially chained TDI -> in[0..N_IN-1] -> out[0..N_OUT-1] -> TDO.
//  Supports BYPASS, SAMPLE/PRELOAD, EXTEST and INTEST modes with capture/shift/update per cell.
//  Tracks the shift count for the TAP-side controller. Sits between chip pins and the CUT (e.g. s9234).
// PARAMETERS
//  N_IN      36       number of input boundary cells (pin -> core)
//  N_OUT     39       number of output boundary cells (core -> pin)
//  SAFE_OUT  {N_OUT{1'b0}}  reset value of the output-cell update latches (pin_out in EXTEST after reset)
//  CNT_W     8        width of shift_cnt
// PORTS
//  TCLK       in   1      test clock; every register updates on its rising edge
//  TRST       in   1      synchronous active-high reset
//  capture_dr in   1      Capture-DR strobe from the TAP controller
//  shift_dr   in   1      Shift-DR strobe
//  update_dr  in   1      Update-DR strobe
//  mode       in   2      00 BYPASS, 01 SAMPLE/PRELOAD, 10 EXTEST, 11 INTEST
//  TDI        in   1      serial scan in
//  TDO        out  1      serial scan out
//  pin_in     in   N_IN   values from chip input pins
//  core_in    out  N_IN   values driven to CUT inputs
//  core_out   in   N_OUT  values from CUT outputs
//  pin_out    out  N_OUT  values driven to chip output pins
//  shift_cnt  out  CNT_W  shift cycles since the last capture, saturating
// BEHAVIOUR
//  Reset (TRST=1 at a TCLK edge): shift cells=0, bypass cell=0, input update latches=0,
//   output update latches=SAFE_OUT, shift_cnt=0. Reset overrides all strobes, including mid-shift.
//  Strobe priority per edge: capture_dr > shift_dr > update_dr; at most one is acted on.
//  BYPASS (00): capture loads bypass cell with 0; shift: bypass<=TDI; TDO=bypass cell.
//   Boundary shift cells and update latches hold. Update is ignored.
//  Other modes: capture: in_sr<=pin_in, out_sr<=core_out (one edge).
//   Shift: in_sr[0]<=TDI, in_sr[i]<=in_sr[i-1], out_sr[0]<=in_sr[N_IN-1], out_sr[j]<=out_sr[j-1].
//   TDO=out_sr[N_OUT-1] (combinational from the register, no extra stage).
//   Update: in_upd<=in_sr, out_upd<=out_sr, in one edge.
//   Bypass cell holds in these modes.
//  Chain length L=N_IN+N_OUT in non-BYPASS modes; first TDI bit reaches TDO after L shift edges.
//  Output muxes (combinational, follow mode immediately, including mid-operation mode changes):
//   pin_out = (mode==EXTEST) ? out_upd : core_out
//   core_in = (mode==INTEST) ? in_upd  : pin_in
//   SAMPLE and BYPASS are transparent to functional data.
//  shift_cnt: cleared on capture_dr, +1 per shift_dr edge (all modes), saturates at 2^CNT_W-1; update holds it.
//  Strobes with none asserted: all state holds.
// TESTING
//  Reset: TRST=1 for 1 edge, mode=EXTEST -> pin_out=SAFE_OUT, TDO=0, shift_cnt=0.
//  SAMPLE: pin_in=36'hA_5A5A_5A5A, core_out=39'h55_AAAA_AAAA; capture, then 75 shifts
//   -> TDO streams core_out[38..0] then pin_in[35..0]; shift_cnt=75.
//  EXTEST preload: shift 75 bits of pattern P, update, mode=10 -> pin_out=P[74:36];
//   core_out toggling does not change pin_out.
//  INTEST: preload in_upd=36'h0_0000_0F0F, mode=11 -> core_in=36'h0_0000_0F0F regardless of pin_in.
//  BYPASS: mode=00, capture, shift TDI=1,0,1 -> TDO=0,1,0 (1-cycle delay); boundary cells and pin_out unchanged.
//  Corner: capture_dr&shift_dr together -> capture only. TRST mid-shift -> all reset values next edge.
//   shift_cnt with CNT_W=4 saturates at 15 after 20 shifts.

Source files
------------

// File: rtl/jtag_bsr_chain_if.sv
// Signal bundle between the TAP-side controller/pins and the boundary-scan register.
// master drives strobes, scan-in and pin/core inputs; slave is the register itself.
interface jtag_bsr_chain_if #(
  parameter int unsigned N_IN  = 36,
  parameter int unsigned N_OUT = 39,
  parameter int unsigned CNT_W = 8
);
  logic             capture_dr;
  logic             shift_dr;
  logic             update_dr;
  logic [1:0]       mode;
  logic             TDI;
  logic             TDO;
  logic [N_IN-1:0]  pin_in;
  logic [N_IN-1:0]  core_in;
  logic [N_OUT-1:0] core_out;
  logic [N_OUT-1:0] pin_out;
  logic [CNT_W-1:0] shift_cnt;

  modport master (
    output capture_dr, shift_dr, update_dr, mode, TDI, pin_in, core_out,
    input  TDO, core_in, pin_out, shift_cnt
  );

  modport slave (
    input  capture_dr, shift_dr, update_dr, mode, TDI, pin_in, core_out,
    output TDO, core_in, pin_out, shift_cnt
  );
endinterface

// File: rtl/jtag_bsr_chain.sv
// Boundary-scan register: TDI -> input cells -> output cells -> TDO, plus a bypass cell,
// with capture/shift/update per cell and a saturating shift counter.
module jtag_bsr_chain #(
  parameter int unsigned      N_IN     = 36,
  parameter int unsigned      N_OUT    = 39,
  parameter logic [N_OUT-1:0] SAFE_OUT = '0,
  parameter int unsigned      CNT_W    = 8
) (
  input logic                TCLK,
  input logic                TRST,
  jtag_bsr_chain_if.slave    bus
);

  localparam logic [1:0] ModeBypass = 2'b00;
  localparam logic [1:0] ModeExtest = 2'b10;
  localparam logic [1:0] ModeIntest = 2'b11;

  logic [N_IN-1:0]  in_sr_q, in_sr_d;
  logic [N_OUT-1:0] out_sr_q, out_sr_d;
  logic [N_IN-1:0]  in_upd_q, in_upd_d;
  logic [N_OUT-1:0] out_upd_q, out_upd_d;
  logic             bypass_q, bypass_d;
  logic [CNT_W-1:0] shift_cnt_q, shift_cnt_d;

  logic             bypass_sel;
  logic [N_IN:0]    in_shifted;
  logic [N_OUT:0]   out_shifted;

  assign bypass_sel  = (bus.mode == ModeBypass);
  // Widened by one so the shift also works for single-cell chains.
  assign in_shifted  = {in_sr_q, bus.TDI};
  assign out_shifted = {out_sr_q, in_sr_q[N_IN-1]};

  always_comb begin
    in_sr_d     = in_sr_q;
    out_sr_d    = out_sr_q;
    in_upd_d    = in_upd_q;
    out_upd_d   = out_upd_q;
    bypass_d    = bypass_q;
    shift_cnt_d = shift_cnt_q;
    if (bus.capture_dr) begin
      shift_cnt_d = '0;
      if (bypass_sel) begin
        bypass_d = 1'b0;
      end else begin
        in_sr_d  = bus.pin_in;
        out_sr_d = bus.core_out;
      end
    end else if (bus.shift_dr) begin
      if (shift_cnt_q != {CNT_W{1'b1}}) begin
        shift_cnt_d = shift_cnt_q + CNT_W'(1);
      end
      if (bypass_sel) begin
        bypass_d = bus.TDI;
      end else begin
        in_sr_d  = in_shifted[N_IN-1:0];
        out_sr_d = out_shifted[N_OUT-1:0];
      end
    end else if (bus.update_dr && !bypass_sel) begin
      in_upd_d  = in_sr_q;
      out_upd_d = out_sr_q;
    end
  end

  always_ff @(posedge TCLK) begin
    if (TRST) begin
      in_sr_q     <= '0;
      out_sr_q    <= '0;
      in_upd_q    <= '0;
      out_upd_q   <= SAFE_OUT;
      bypass_q    <= 1'b0;
      shift_cnt_q <= '0;
    end else begin
      in_sr_q     <= in_sr_d;
      out_sr_q    <= out_sr_d;
      in_upd_q    <= in_upd_d;
      out_upd_q   <= out_upd_d;
      bypass_q    <= bypass_d;
      shift_cnt_q <= shift_cnt_d;
    end
  end

  assign bus.TDO       = bypass_sel ? bypass_q : out_sr_q[N_OUT-1];
  assign bus.pin_out   = (bus.mode == ModeExtest) ? out_upd_q : bus.core_out;
  assign bus.core_in   = (bus.mode == ModeIntest) ? in_upd_q : bus.pin_in;
  assign bus.shift_cnt = shift_cnt_q;

endmodule
